// File: rtl/sccb_cfg_pkg.sv
// Shared types and constants for the SCCB configuration sequencer.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package sccb_cfg_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DECODE,
        ST_SEND,
        ST_GUARD,
        ST_DELAY,
        ST_DONE
    } state_t;

    // Table markers: 16'hFFFF ends the table, 16'hFExx waits xx milliseconds.
    localparam logic [15:0] CFG_END     = 16'hFFFF;
    localparam logic [7:0]  CFG_DLY_TAG = 8'hFE;

    // Terminal count of the 1 ms divider. Clocks slower than 2 kHz tick every cycle.
    function automatic int unsigned ms_tick_tc(input int unsigned clk_hz);
        if (clk_hz < 32'd2000) begin
            return 0;
        end
        return (clk_hz / 1000) - 1;
    endfunction

endpackage

// File: rtl/sccb_ms_tick.sv
// 1 ms pulse generator with synchronous clear; restarts its count whenever i_clr is high.
// Latency: first o_tick is ms_tick_tc(CLK_HZ) cycles after i_clr drops, then one per period.
// Backpressure: none; o_tick is a single-cycle strobe.
// Ports: i_clk, i_rst (async, active-high), i_clr (hold divider at zero), o_tick (1 ms strobe).
module sccb_ms_tick
    import sccb_cfg_pkg::*;
#(
    parameter int unsigned CLK_HZ = 27000000
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clr,
    output logic o_tick
);

    localparam logic [31:0] TC = 32'(ms_tick_tc(CLK_HZ));

    logic [31:0] r_cnt;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (i_clr || (r_cnt == TC)) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 32'd1;
        end
    end

    assign o_tick = !i_clr && (r_cnt == TC);

endmodule

// File: rtl/sccb_cfg_sequencer.sv
// Walks a {reg,val} configuration ROM and hands each pair to the SCCB write engine.
// Latency: start to first o_send = 3 cycles; done follows TXN_GUARD cycles after the last take.
// Backpressure: o_send/o_rega/o_value held stable until i_taken; one entry in flight at a time.
// Ports: i_clk, i_rst (async, active-high), i_start pulse, o_rom_addr / i_rom_data (sync ROM),
//        o_send / o_rega / o_value / i_taken (engine handshake), o_busy, o_done, o_error.
// Optional: define CFG_WATCHDOG_EN to abort a SEND that sees no i_taken for WDOG_CYCLES.
module sccb_cfg_sequencer
    import sccb_cfg_pkg::*;
#(
    parameter int unsigned ROM_AW      = 8,
    parameter int unsigned CLK_HZ      = 27000000,
    parameter int unsigned TXN_GUARD   = 8448,
    parameter int unsigned WDOG_CYCLES = 65536
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    output logic [ROM_AW-1:0] o_rom_addr,
    input  logic [15:0]       i_rom_data,
    output logic              o_send,
    output logic [7:0]        o_rega,
    output logic [7:0]        o_value,
    input  logic              i_taken,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_error
);

    localparam logic [ROM_AW-1:0] ADDR_LAST  = '1;
    localparam logic [ROM_AW-1:0] ADDR_ONE   = ROM_AW'(1);
    localparam logic [31:0]       GUARD_LOAD = 32'(TXN_GUARD);

    state_t            r_state,    w_state;
    logic [ROM_AW-1:0] r_rom_addr, w_rom_addr;
    logic              r_send,     w_send;
    logic [7:0]        r_rega,     w_rega;
    logic [7:0]        r_value,    w_value;
    logic              r_busy,     w_busy;
    logic              r_done,     w_done;
    logic [31:0]       r_guard,    w_guard;
    logic [7:0]        r_ms,       w_ms;
    logic              r_to_done,  w_to_done;   // GUARD exit target: DONE (1) or DELAY (0)
    logic              w_tick;
    logic              w_tick_clr;
    logic              w_wdog_fire;

    // Divider only runs while dwelling in DELAY so every delay starts on a fresh period.
    assign w_tick_clr = (r_state != ST_DELAY);

    sccb_ms_tick #(
        .CLK_HZ (CLK_HZ)
    ) u_ms_tick (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_clr  (w_tick_clr),
        .o_tick (w_tick)
    );

`ifdef CFG_WATCHDOG_EN
    localparam logic [31:0] WDOG_LAST = 32'(WDOG_CYCLES - 1);

    logic [31:0] r_wdog;
    logic        r_error;

    assign w_wdog_fire = (r_state == ST_SEND) && !i_taken && (r_wdog == WDOG_LAST);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wdog  <= '0;
            r_error <= 1'b0;
        end else begin
            r_wdog <= ((r_state == ST_SEND) && !i_taken) ? r_wdog + 32'd1 : '0;
            if ((r_state == ST_IDLE) && i_start) begin
                r_error <= 1'b0;
            end else if (w_wdog_fire) begin
                r_error <= 1'b1;
            end
        end
    end

    assign o_error = r_error;
`else
    assign w_wdog_fire = 1'b0;
    assign o_error     = 1'b0;
`endif

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state    <= ST_IDLE;
            r_rom_addr <= '0;
            r_send     <= 1'b0;
            r_rega     <= '0;
            r_value    <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_guard    <= '0;
            r_ms       <= '0;
            r_to_done  <= 1'b0;
        end else begin
            r_state    <= w_state;
            r_rom_addr <= w_rom_addr;
            r_send     <= w_send;
            r_rega     <= w_rega;
            r_value    <= w_value;
            r_busy     <= w_busy;
            r_done     <= w_done;
            r_guard    <= w_guard;
            r_ms       <= w_ms;
            r_to_done  <= w_to_done;
        end
    end

    always_comb begin
        w_state    = r_state;
        w_rom_addr = r_rom_addr;
        w_send     = r_send;
        w_rega     = r_rega;
        w_value    = r_value;
        w_busy     = r_busy;
        w_done     = r_done;
        w_ms       = r_ms;
        w_to_done  = r_to_done;
        // The guard counter free-runs down through FETCH/DECODE/SEND so the
        // wait after the last write overlaps with walking the next entries.
        w_guard    = (r_guard != '0) ? r_guard - 32'd1 : '0;

        case (r_state)
            ST_IDLE: begin
                if (i_start) begin
                    w_done     = 1'b0;
                    w_busy     = 1'b1;
                    w_rom_addr = '0;
                    w_guard    = '0;
                    w_state    = ST_FETCH;
                end
            end
            ST_FETCH: begin
                w_state = ST_DECODE;
            end
            ST_DECODE: begin
                if (i_rom_data == CFG_END) begin
                    w_to_done = 1'b1;
                    w_state   = ST_GUARD;
                end else if (i_rom_data[15:8] == CFG_DLY_TAG) begin
                    w_ms      = i_rom_data[7:0];
                    w_to_done = 1'b0;
                    w_state   = ST_GUARD;
                end else begin
                    w_rega  = i_rom_data[15:8];
                    w_value = i_rom_data[7:0];
                    w_send  = 1'b1;
                    w_state = ST_SEND;
                end
            end
            ST_SEND: begin
                if (i_taken) begin
                    w_send  = 1'b0;
                    w_guard = GUARD_LOAD;
                    // Last ROM slot consumed: finish instead of wrapping to entry 0.
                    if (r_rom_addr == ADDR_LAST) begin
                        w_to_done = 1'b1;
                        w_state   = ST_GUARD;
                    end else begin
                        w_rom_addr = r_rom_addr + ADDR_ONE;
                        w_state    = ST_FETCH;
                    end
                end else if (w_wdog_fire) begin
                    w_send  = 1'b0;
                    w_busy  = 1'b0;
                    w_state = ST_IDLE;
                end
            end
            ST_GUARD: begin
                if (r_guard == '0) begin
                    w_state = r_to_done ? ST_DONE : ST_DELAY;
                end
            end
            ST_DELAY: begin
                if (r_ms == '0) begin
                    if (r_rom_addr == ADDR_LAST) begin
                        w_state = ST_DONE;
                    end else begin
                        w_rom_addr = r_rom_addr + ADDR_ONE;
                        w_state    = ST_FETCH;
                    end
                end else if (w_tick) begin
                    w_ms = r_ms - 8'd1;
                end
            end
            ST_DONE: begin
                w_busy  = 1'b0;
                w_done  = 1'b1;
                w_state = ST_IDLE;
            end
            default: begin
                w_state = ST_IDLE;
            end
        endcase
    end

    assign o_rom_addr = r_rom_addr;
    assign o_send     = r_send;
    assign o_rega     = r_rega;
    assign o_value    = r_value;
    assign o_busy     = r_busy;
    assign o_done     = r_done;

endmodule

// File: tb/tb_sccb_cfg_sequencer.sv
// Self-checking bench for sccb_cfg_sequencer: ROM model, engine model, table-level reference.
// Latency: n/a.
// Backpressure: engine model asserts taken a programmable number of cycles after send.
module tb_sccb_cfg_sequencer;

    localparam int ROM_AW    = 8;
    localparam int CLK_HZ    = 1000;
    localparam int TXN_GUARD = 40;
    localparam int WDOG      = 100;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  rom_addr;
    logic [15:0] rom_data;
    logic        send;
    logic [7:0]  rega;
    logic [7:0]  value;
    logic        taken;
    logic        busy;
    logic        done;
    logic        error;

    logic [15:0] rom [256];
    logic [15:0] got_q [$];
    logic [15:0] exp_q [$];

    int  n_checks = 0;
    int  n_pass   = 0;
    bit  eng_en   = 1'b0;
    int  eng_lat  = 5;
    bit  spur_en  = 1'b0;
    int  mon_wrap = 0;
    int  mon_gap  = 0;
    int  base     = 0;
    int  r_send_k, r_done_k, r_take_k;

    always #5 clk = ~clk;

    sccb_cfg_sequencer #(
        .ROM_AW      (ROM_AW),
        .CLK_HZ      (CLK_HZ),
        .TXN_GUARD   (TXN_GUARD),
        .WDOG_CYCLES (WDOG)
    ) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_start    (start),
        .o_rom_addr (rom_addr),
        .i_rom_data (rom_data),
        .o_send     (send),
        .o_rega     (rega),
        .o_value    (value),
        .i_taken    (taken),
        .o_busy     (busy),
        .o_done     (done),
        .o_error    (error)
    );

    // Synchronous ROM: data for the address presented at one edge appears after the next.
    initial forever begin
        @(posedge clk);
        rom_data <= rom[rom_addr];
    end

    // Engine model: latch the pair eng_lat cycles into a request; optionally
    // inject stray taken pulses while no request is pending.
    initial begin
        int cnt;
        cnt   = 0;
        taken = 1'b0;
        forever begin
            @(negedge clk);
            taken = 1'b0;
            if (rst || !send) cnt = 0;
            if (send && eng_en && !rst) begin
                cnt++;
                if (cnt >= eng_lat) begin
                    taken = 1'b1;
                    got_q.push_back({rega, value});
                    cnt = 0;
                end
            end else if (!send && spur_en && ($urandom_range(0, 3) == 0)) begin
                taken = 1'b1;
            end
        end
    end

    // Monitor: address must never fall back to 0 mid-run; send must idle >= 2 cycles between entries.
    initial begin
        logic [7:0] prev_addr;
        logic       prev_send;
        int         low_run;
        bit         seen_fall;
        prev_addr = '0; prev_send = 1'b0; low_run = 0; seen_fall = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_addr = '0; prev_send = 1'b0; low_run = 0; seen_fall = 1'b0;
            end else begin
                if (busy && (rom_addr == 8'd0) && (prev_addr != 8'd0)) mon_wrap++;
                if (send && !prev_send && seen_fall && (low_run < 2)) mon_gap++;
                if (!send && prev_send) begin
                    seen_fall = 1'b1;
                    low_run   = 0;
                end
                if (!send) low_run++;
                prev_send = send;
                prev_addr = busy ? rom_addr : 8'd0;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "simulation time limit");
    end

    task automatic check(input string tag, input longint obs, input longint expv);
        n_checks++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    endtask

    task automatic check_range(input string tag, input longint obs, input longint lo, input longint hi);
        n_checks++;
        assert (obs >= lo && obs <= hi) n_pass++;
        else $error("FAIL %s observed=%0d expected=%0d..%0d", tag, obs, lo, hi);
    endtask

    function automatic logic [15:0] rand_wr();
        logic [7:0] r;
        logic [7:0] v;
        r = 8'($urandom_range(0, 253));
        v = 8'($urandom_range(0, 255));
        return {r, v};
    endfunction

    task automatic fill_end();
        for (int a = 0; a < 256; a++) rom[a] = 16'hFFFF;
    endtask

    // Reference: the writes a table should produce, in order, stopping at the
    // end marker or after the last ROM slot; delay entries produce no write.
    task automatic build_exp();
        exp_q.delete();
        for (int a = 0; a < 256; a++) begin
            if (rom[a] == 16'hFFFF) break;
            if (rom[a][15:8] != 8'hFE) exp_q.push_back(rom[a]);
        end
    endtask

    task automatic compare_writes(input string tag);
        int n;
        int bad;
        n = got_q.size() - base;
        check({tag, "_count"}, n, exp_q.size());
        bad = 0;
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i >= n) bad++;
            else if (got_q[base + i] !== exp_q[i]) bad++;
        end
        check({tag, "_data_bad"}, bad, 0);
    endtask

    // Pulse start and follow the run until done; k counts edges after the start edge.
    task automatic run_seq(input string tag, input int budget, input bit noise);
        int k;
        bit fin;
        r_send_k = -1; r_done_k = -1; r_take_k = -1;
        base = got_q.size();
        @(negedge clk);
        start = 1'b1;
        k = 0;
        fin = 1'b0;
        while (!fin && k < budget) begin
            @(posedge clk);
            #1;
            k++;
            start = 1'b0;
            if (noise && busy && ($urandom_range(0, 7) == 0)) start = 1'b1;
            if (send && r_send_k < 0) r_send_k = k;
            if (taken && !spur_en) r_take_k = k;
            if (done) begin
                r_done_k = k;
                fin = 1'b1;
            end
        end
        start = 1'b0;
        check({tag, "_finished"}, fin, 1);
    endtask

    initial begin
        int t0, t5, xx, k, ks, ke;
        bit hit;

        // ---------------- reset state ----------------
        #2 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_send", send, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_error", error, 0);
        check("rst_addr", rom_addr, 0);
        @(negedge clk);
        rst = 1'b0;

        // ---------------- two writes then end ----------------
        fill_end();
        rom[0] = 16'h1204;
        rom[1] = 16'h1100;
        build_exp();
        eng_en = 1'b1;
        eng_lat = 5;
        run_seq("basic", 500, 1'b0);
        check("basic_start_to_send", r_send_k, 3);
        compare_writes("basic");
        check_range("basic_done_after_take", r_done_k - r_take_k, TXN_GUARD, TXN_GUARD + 3);
        check("basic_busy_after_done", busy, 0);
        check("basic_error", error, 0);

        // ---------------- delay entries ----------------
        fill_end();
        rom[0] = 16'hFE00;
        build_exp();
        run_seq("dly0", 500, 1'b0);
        t0 = r_done_k;
        check("dly0_no_send", r_send_k, -1);
        fill_end();
        rom[0] = 16'hFE05;
        run_seq("dly5", 500, 1'b0);
        t5 = r_done_k;
        check("dly5_no_send", r_send_k, -1);
        compare_writes("dly5");
        check_range("dly5_dwell", t5 - t0, 4, 6);
        check("dly5_done", done, 1);

        // random delay with stray start and stray taken
        xx = $urandom_range(1, 30);
        rom[0] = {8'hFE, 8'(xx)};
        spur_en = 1'b1;
        run_seq("dlyr", 500, 1'b1);
        spur_en = 1'b0;
        check("dlyr_no_send", r_send_k, -1);
        compare_writes("dlyr");
        check_range("dlyr_dwell", r_done_k - t0, xx - 1, xx + 1);

        // ---------------- reset while send is high ----------------
        fill_end();
        for (int a = 0; a < 5; a++) rom[a] = rand_wr();
        build_exp();
        eng_lat = 3;
        base = got_q.size();
        @(negedge clk);
        start = 1'b1;
        hit = 1'b0;
        k = 0;
        while (!hit && k < 200) begin
            @(posedge clk);
            #1;
            k++;
            start = 1'b0;
            if ((got_q.size() - base >= 2) && send) hit = 1'b1;
        end
        check("midrst_reached", hit, 1);
        rst = 1'b1;
        #1;
        check("midrst_send", send, 0);
        check("midrst_busy", busy, 0);
        check("midrst_addr", rom_addr, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        run_seq("replay", 2000, 1'b0);
        compare_writes("replay");

        // ---------------- full table, no end marker ----------------
        for (int a = 0; a < 256; a++) rom[a] = rand_wr();
        build_exp();
        eng_lat = 2;
        k = mon_wrap;
        run_seq("full", 5000, 1'b0);
        compare_writes("full");
        check("full_no_wrap", mon_wrap - k, 0);
        check("full_addr_end", rom_addr, 255);

        // ---------------- random tables ----------------
        for (int it = 0; it < 6; it++) begin
            int n;
            fill_end();
            n = $urandom_range(1, 15);
            for (int a = 0; a < n; a++) begin
                if ($urandom_range(0, 3) == 0) rom[a] = {8'hFE, 8'($urandom_range(0, 4))};
                else rom[a] = rand_wr();
            end
            eng_lat = $urandom_range(1, 6);
            build_exp();
            spur_en = 1'b1;
            run_seq("rand", 5000, 1'b1);
            spur_en = 1'b0;
            compare_writes("rand");
        end
        check("send_gap", mon_gap, 0);

`ifdef CFG_WATCHDOG_EN
        // ---------------- watchdog ----------------
        fill_end();
        rom[0] = 16'h1204;
        eng_en = 1'b0;
        @(negedge clk);
        start = 1'b1;
        ks = -1; ke = -1; k = 0;
        while (ke < 0 && k < 400) begin
            @(posedge clk);
            #1;
            k++;
            start = 1'b0;
            if (send && ks < 0) ks = k;
            if (error) ke = k;
        end
        check("wdog_fired", (ke > 0) ? 1 : 0, 1);
        check_range("wdog_cycles", ke - ks, WDOG - 1, WDOG + 1);
        check("wdog_send", send, 0);
        check("wdog_done", done, 0);
        check("wdog_busy", busy, 0);
        eng_en = 1'b1;
        build_exp();
        run_seq("wdog_restart", 500, 1'b0);
        check("wdog_error_cleared", error, 0);
        compare_writes("wdog_restart");
`else
        check("error_tied_low", error, 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
